// File: rtl/ddr3_user_arbiter_if.sv
// Bundle of requester A/B and DDR3 controller user-port signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is user logic plus controller.
interface ddr3_user_arbiter_if #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16
);
    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;

    logic                   a_req, a_write;
    logic [AW-1:0]          a_addr;
    logic [DQ_BITWIDTH-1:0] a_wdata;
    logic                   b_req, b_write;
    logic [AW-1:0]          b_addr;
    logic [DQ_BITWIDTH-1:0] b_wdata;

    logic                   a_gnt, b_gnt;
    logic [DQ_BITWIDTH-1:0] a_rdata, b_rdata;
    logic                   a_rvalid, b_rvalid;

    logic                   write_enable, read_enable;
    logic [AW-1:0]          i_user_data_address;
    logic [DQ_BITWIDTH-1:0] i_user_data;
    logic                   ctrl_ready;
    logic [DQ_BITWIDTH-1:0] o_user_data;
    logic                   ctrl_rvalid;
    logic                   err_spurious_rd;

    modport slave (
        input  a_req, a_write, a_addr, a_wdata,
        input  b_req, b_write, b_addr, b_wdata,
        input  ctrl_ready, o_user_data, ctrl_rvalid,
        output a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
        output write_enable, read_enable, i_user_data_address, i_user_data,
        output err_spurious_rd
    );

    modport master (
        output a_req, a_write, a_addr, a_wdata,
        output b_req, b_write, b_addr, b_wdata,
        output ctrl_ready, o_user_data, ctrl_rvalid,
        input  a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
        input  write_enable, read_enable, i_user_data_address, i_user_data,
        input  err_spurious_rd
    );
endinterface

// File: rtl/ddr3_user_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller user port between requesters A and B.
// Read data is steered back to the issuing requester via an in-order tag FIFO.
module ddr3_user_arbiter #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int TAG_FIFO_DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ddr3_user_arbiter_if.slave   bus
);
    localparam int AW    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(TAG_FIFO_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state, state_next;
    logic                   rr_b;
    logic                   tag_mem [TAG_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count;

    logic                   a_elig, b_elig, any_elig, grant_b;
    logic                   win_write, push, pop;
    logic [AW-1:0]          win_addr;
    logic [DQ_BITWIDTH-1:0] win_data;

    // Eligibility uses the registered count, so a pop in the same cycle never frees a slot early.
    always_comb begin
        a_elig     = bus.a_req & (bus.a_write | (count < FIFO_FULL));
        b_elig     = bus.b_req & (bus.b_write | (count < FIFO_FULL));
        any_elig   = a_elig | b_elig;
        grant_b    = b_elig & (~a_elig | rr_b);
        win_write  = grant_b ? bus.b_write : bus.a_write;
        win_addr   = grant_b ? bus.b_addr  : bus.a_addr;
        win_data   = grant_b ? bus.b_wdata : bus.a_wdata;
        push       = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    push       = ~win_write;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ctrl_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        pop = bus.ctrl_rvalid & (count != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            rr_b                    <= 1'b0;
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            count                   <= '0;
            bus.a_gnt               <= 1'b0;
            bus.b_gnt               <= 1'b0;
            bus.a_rvalid            <= 1'b0;
            bus.b_rvalid            <= 1'b0;
            bus.a_rdata             <= '0;
            bus.b_rdata             <= '0;
            bus.write_enable        <= 1'b0;
            bus.read_enable         <= 1'b0;
            bus.i_user_data_address <= '0;
            bus.i_user_data         <= '0;
            bus.err_spurious_rd     <= 1'b0;
        end else begin
            state        <= state_next;
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;

            if (state == IDLE && any_elig) begin
                bus.i_user_data_address <= win_addr;
                bus.i_user_data         <= win_data;
                bus.write_enable        <= win_write;
                bus.read_enable         <= ~win_write;
                bus.a_gnt               <= ~grant_b;
                bus.b_gnt               <= grant_b;
                rr_b                    <= ~grant_b;
            end else if (state == ISSUE && bus.ctrl_ready) begin
                bus.write_enable <= 1'b0;
                bus.read_enable  <= 1'b0;
            end

            if (push) begin
                tag_mem[wr_ptr] <= grant_b;
                wr_ptr          <= wr_ptr + 1'b1;
            end

            // Data arriving with no outstanding read has no owner: drop it and flag.
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (tag_mem[rd_ptr]) begin
                    bus.b_rdata  <= bus.o_user_data;
                    bus.b_rvalid <= 1'b1;
                end else begin
                    bus.a_rdata  <= bus.o_user_data;
                    bus.a_rvalid <= 1'b1;
                end
            end else if (bus.ctrl_rvalid) begin
                bus.err_spurious_rd <= 1'b1;
            end

            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule
